// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
// Couples a byte-oriented host interface to a uart_controller through two
// FIFOs. The TX FIFO is drained by a small FSM that issues one-cycle send
// requests and tracks the controller's busy handshake. The RX FSM takes each
// pending received byte, pushes it (or drops it and raises a sticky overflow
// flag when there is no room), then acknowledges it for one cycle.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   tx_wdata, tx_we   : host enqueue into the TX FIFO
//   tx_full, tx_count : TX FIFO status
//   rx_rdata, rx_re   : RX FIFO head (show-ahead) and dequeue strobe
//   rx_empty, rx_count: RX FIFO status
//   rx_overflow       : sticky dropped-byte flag, cleared by overflow_clr
//   send_data, send   : transmit request to the uart_controller
//   send_busy         : uart_controller transmitter busy
//   rev_data, rev_data_valid, rev_data_invalid : receive handshake
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_wdata,
    input  logic          tx_we,
    output logic          tx_full,
    output logic [CW-1:0] tx_count,
    output logic [7:0]    rx_rdata,
    input  logic          rx_re,
    output logic          rx_empty,
    output logic [CW-1:0] rx_count,
    output logic          rx_overflow,
    input  logic          overflow_clr,
    output logic [7:0]    send_data,
    output logic          send,
    input  logic          send_busy,
    input  logic [7:0]    rev_data,
    input  logic          rev_data_valid,
    output logic          rev_data_invalid
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        T_IDLE      = 2'd0,
        T_ISSUE     = 2'd1,
        T_WAIT_BUSY = 2'd2,
        T_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp;
    logic [AW-1:0] r_tx_rp;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [CW-1:0] r_rx_cnt;
    tx_state_t     r_tx_state;
    rx_state_t     r_rx_state;
    logic          r_send;
    logic [7:0]    r_send_data;
    logic          r_rev_ack;
    logic          r_rx_ovf;

    tx_state_t     w_tx_next;
    rx_state_t     w_rx_next;
    logic          w_tx_full;
    logic          w_rx_empty;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_rx_offer;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_ovf_set;

    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == {CW{1'b0}});
    // A write into a full TX FIFO is dropped even if the FSM pops this cycle.
    assign w_tx_push  = tx_we & ~w_tx_full;
    assign w_tx_pop   = (r_tx_state == T_ISSUE);
    assign w_rx_pop   = rx_re & ~w_rx_empty;
    assign w_rx_offer = (r_rx_state == R_IDLE) & rev_data_valid;
    // A full RX FIFO still accepts the byte when a pop frees a slot this cycle.
    assign w_rx_push  = w_rx_offer & ((r_rx_cnt != FULL_CNT) | w_rx_pop);
    assign w_ovf_set  = w_rx_offer & ~w_rx_push;

    assign tx_full          = w_tx_full;
    assign tx_count         = r_tx_cnt;
    assign rx_empty         = w_rx_empty;
    assign rx_count         = r_rx_cnt;
    assign rx_rdata         = r_rx_mem[r_rx_rp];
    assign rx_overflow      = r_rx_ovf;
    assign send             = r_send;
    assign send_data        = r_send_data;
    assign rev_data_invalid = r_rev_ack;

    // FIFO storage writes; contents are not reset and are meaningless after reset.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_wdata;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= rev_data;
    end

    // TX FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp  <= {AW{1'b0}};
            r_tx_rp  <= {AW{1'b0}};
            r_tx_cnt <= {CW{1'b0}};
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1'b1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1'b1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1'b1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1'b1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp  <= {AW{1'b0}};
            r_rx_rp  <= {AW{1'b0}};
            r_rx_cnt <= {CW{1'b0}};
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1'b1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1'b1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1'b1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1'b1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // TX FSM next state. Issuing only from idle with busy low also covers a
    // reset that lands mid-frame: the bridge waits for the controller to finish.
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            T_IDLE: begin
                if ((r_tx_cnt != {CW{1'b0}}) && !send_busy) w_tx_next = T_ISSUE;
                else                                         w_tx_next = T_IDLE;
            end
            T_ISSUE:     w_tx_next = T_WAIT_BUSY;
            T_WAIT_BUSY: begin
                if (send_busy) w_tx_next = T_WAIT_DONE;
                else           w_tx_next = T_WAIT_BUSY;
            end
            T_WAIT_DONE: begin
                if (!send_busy) w_tx_next = T_IDLE;
                else            w_tx_next = T_WAIT_DONE;
            end
            default:     w_tx_next = T_IDLE;
        endcase
    end

    // TX FSM state plus registered send strobe and held send byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= T_IDLE;
            r_send      <= 1'b0;
            r_send_data <= 8'h00;
        end else begin
            r_tx_state <= w_tx_next;
            r_send     <= (w_tx_next == T_ISSUE);
            if (w_tx_next == T_ISSUE) r_send_data <= r_tx_mem[r_tx_rp];
        end
    end

    // RX FSM next state: one acknowledge cycle per received byte.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE: begin
                if (rev_data_valid) w_rx_next = R_ACK;
                else                w_rx_next = R_IDLE;
            end
            R_ACK:   w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // RX FSM state, registered acknowledge and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_rev_ack  <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rev_ack  <= (w_rx_next == R_ACK);
            if (w_ovf_set)         r_rx_ovf <= 1'b1;
            else if (overflow_clr) r_rx_ovf <= 1'b0;
        end
    end
endmodule
